udp_rx_parser: RTL and testbench
================================

Name: udp_rx_parser

Overview:
- Parametrised receive-side Ethernet/IPv4/UDP header parser.
- Sits between the MAC receive byte stream (preamble/SFD/FCS already stripped, FCS verdict supplied on last byte) and application logic.
- Filters frames by MAC, IP and a contiguous range of NUM_CHAN UDP ports.
- Skips IP options and emits the UDP payload tagged with a channel index, plus a per-frame status pulse and good/drop counters.

Parameters:
- LOCAL_MAC, 48'h02_00_00_00_00_01, accepted destination MAC; ff:ff:ff:ff:ff:ff is also always accepted.
- LOCAL_IP, 32'hC0A8_0164, accepted destination IPv4 address (192.168.1.100).
- PORT_BASE, 16'd5000, UDP port of channel 0.
- NUM_CHAN, 4, number of channels; channel i = port PORT_BASE+i; range 1..16.
- CNT_W, 32, width of the statistics counters.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  input byte valid
- in_data  in  8  frame byte; first valid byte after reset or after in_last is dest MAC byte 0
- in_last  in  1  final byte of frame (qualified by in_valid)
- in_fcs_bad  in  1  FCS failed (qualified by in_valid & in_last)
- out_valid  out  1  payload byte valid
- out_data  out  8  payload byte
- out_last  out  1  last payload byte
- out_chan  out  $clog2(NUM_CHAN)+1  channel index (held for whole payload)
- stat_valid  out  1  one-cycle end-of-frame status pulse
- stat_good  out  1  frame accepted and intact (qualified by stat_valid)
- rx_good_cnt  out  CNT_W  accepted frame count
- rx_drop_cnt  out  CNT_W  dropped frame count

Behaviour:
- One clock domain, clk. Reset is synchronous and active-high via rst. No backpressure. The upstream MAC shares rst, so the first byte after reset is a frame start.
- Reset values: every output is 0; counters are 0; state is IDLE.
- States: IDLE, ETH_HEADER, IP_HEADER, IP_OPTIONS, UDP_HEADER, PAYLOAD, PAD, DROP.
- An internal byte counter is cleared on every state change.
- IDLE: the first in_valid byte goes to ETH_HEADER (counted as byte 0).
- ETH_HEADER (14 bytes):
  - Dest MAC must equal LOCAL_MAC or broadcast.
  - EtherType must be 0x0800.
  - Otherwise go to DROP.
- IP_HEADER (20 bytes). Go to DROP if any of: version != 4, IHL < 5, protocol != 17, MF flag set, frag_offset != 0, dest IP != LOCAL_IP.
- IP_OPTIONS: skip (IHL-5)*4 bytes. Entered only when IHL > 5.
- UDP_HEADER (8 bytes):
  - Channel = dest_port - PORT_BASE; it must lie in 0..NUM_CHAN-1, else DROP.
  - udp_len < 8 -> DROP.
  - udp_len == 8 -> PAD.
  - Otherwise load remaining = udp_len - 8 (16-bit) and go to PAYLOAD.
- PAYLOAD:
  - Each input byte is registered to out_data with out_valid one cycle later (latency 1).
  - out_last is set when remaining reaches 1, then go to PAD.
- PAD: discard Ethernet padding bytes until in_last.
- DROP: discard bytes until in_last.
- End of frame, on in_valid & in_last in any state:
  - Next cycle: stat_valid=1 and stat_good = (frame accepted) & !in_fcs_bad & !truncated.
  - Increment exactly one of rx_good_cnt / rx_drop_cnt.
  - Return to IDLE.
- Truncation: in_last before PAYLOAD completes.
  - If in PAYLOAD, that byte is emitted with out_last=1.
  - stat_good=0.
- in_last during a header state counts as a drop; no payload is emitted.
- Counters wrap at 2^CNT_W.
- rst asserted mid-frame: all outputs drop to 0 the next cycle and any partial payload is abandoned with no out_last.

Optional Feature:
- IP_CSUM_CHECK_EN defined:
  - Accumulate the 16-bit one's-complement sum over the IHL*4 header bytes (options included).
  - A final folded sum != 16'hFFFF forces DROP at the header end; no payload is emitted.
- Undefined: the checksum is ignored and the accumulator logic is absent.

Decomposition:
- Add to eth_types_pkg:
  - Enum udp_rx_state_e with the states above.
  - Constants ETHERTYPE_IPV4=16'h0800, IP_PROTO_UDP=8'd17, ETH_HDR_LEN=14, IP_HDR_MIN_LEN=20, UDP_HDR_LEN=8.
- One sub-module, ip_csum_acc: byte-serial one's-complement accumulator with clear, byte-valid and end-around-carry fold, instantiated only under IP_CSUM_CHECK_EN.

Test Plan:
- Frame to LOCAL_MAC/LOCAL_IP, port 5002, udp_len=12, payload DE AD BE EF, padded to 60 bytes -> 4 out_valid beats, out_chan=2, out_last on EF, stat_good=1, rx_good_cnt=1.
- Same frame with port 5004 (NUM_CHAN=4) -> no out_valid, stat_good=0, rx_drop_cnt=1.
- Same frame with IHL=6 plus 4 option bytes -> payload identical to the first case.
- Truncation: in_last on payload byte 2 of 4 -> out_last on byte 2, stat_good=0.
- Valid frame with in_fcs_bad=1 -> payload emitted, stat_good=0, drop counted.
- Under IP_CSUM_CHECK_EN, header checksum corrupted by 0x0001 -> no payload, drop counted. Broadcast dest MAC with a valid frame -> accepted.

Source files
------------

// File: rtl/eth_types_pkg.sv
// Shared Ethernet/IPv4/UDP types and constants for the receive-side parser.
// Also provides the one's-complement add used by the header checksum accumulator.
package eth_types_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ETH_HEADER,
        IP_HEADER,
        IP_OPTIONS,
        UDP_HEADER,
        PAYLOAD,
        PAD,
        DROP
    } udp_rx_state_e;

    localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  IP_PROTO_UDP   = 8'd17;
    localparam logic [7:0]  ETH_HDR_LEN    = 8'd14;
    localparam logic [7:0]  IP_HDR_MIN_LEN = 8'd20;
    localparam logic [7:0]  UDP_HDR_LEN    = 8'd8;

    // 16-bit one's-complement addition with the end-around carry folded back in.
    function automatic logic [15:0] csum_add(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[15:0] + {15'd0, s[16]};
    endfunction

endpackage

// File: rtl/ip_csum_acc.sv
// Byte-serial IPv4 header checksum accumulator (big-endian 16-bit words).
// Only built when IP_CSUM_CHECK_EN is defined; the parser has no accumulator otherwise.
`ifdef IP_CSUM_CHECK_EN
module ip_csum_acc
    import eth_types_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic [15:0] sum
);

    logic [15:0] acc;
    logic [7:0]  hi_byte;
    logic        odd;

    // sum already includes a word completed by the byte presented this cycle,
    // so the parser can judge the header on its final byte.
    assign sum = (byte_valid && odd) ? csum_add(acc, {hi_byte, byte_data}) : acc;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            acc     <= '0;
            hi_byte <= '0;
            odd     <= 1'b0;
        end else if (byte_valid) begin
            if (odd) begin
                acc <= sum;
            end else begin
                hi_byte <= byte_data;
            end
            odd <= !odd;
        end
    end

endmodule
`endif

// File: rtl/udp_rx_parser.sv
// Receive-side Ethernet/IPv4/UDP header parser: filters by MAC, IP and a UDP port range,
// emits the payload tagged with a channel index. Define IP_CSUM_CHECK_EN to enforce the IP header checksum.
module udp_rx_parser
    import eth_types_pkg::*;
#(
    parameter logic [47:0] LOCAL_MAC = 48'h02_00_00_00_00_01,
    parameter logic [31:0] LOCAL_IP  = 32'hC0A8_0164,
    parameter logic [15:0] PORT_BASE = 16'd5000,
    parameter int          NUM_CHAN  = 4,
    parameter int          CNT_W     = 32,
    localparam int         CHAN_W    = $clog2(NUM_CHAN) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    input  logic              in_last,
    input  logic              in_fcs_bad,
    output logic              out_valid,
    output logic [7:0]        out_data,
    output logic              out_last,
    output logic [CHAN_W-1:0] out_chan,
    output logic              stat_valid,
    output logic              stat_good,
    output logic [CNT_W-1:0]  rx_good_cnt,
    output logic [CNT_W-1:0]  rx_drop_cnt
);

    localparam logic [15:0] NUM_CHAN_16 = 16'(NUM_CHAN);

    udp_rx_state_e     state;
    logic [7:0]        cnt;
    logic              mac_uc_ok;
    logic              mac_bc_ok;
    logic [3:0]        ihl;
    logic [7:0]        hi_byte;
    logic [15:0]       udp_len;
    logic [15:0]       remaining;
    logic              chan_ok;
    logic [CHAN_W-1:0] chan_r;

    function automatic logic [7:0] mac_byte(input logic [7:0] idx);
        logic [47:0] sh;
        sh = LOCAL_MAC << {idx, 3'b000};
        return sh[47:40];
    endfunction

    function automatic logic [7:0] ip_byte(input logic [1:0] idx);
        logic [31:0] sh;
        sh = LOCAL_IP << {idx, 3'b000};
        return sh[31:24];
    endfunction

    // Byte 0 is consumed in IDLE, so the Ethernet header index runs one ahead of cnt.
    logic [7:0]  eth_idx;
    logic        mac_uc_next;
    logic        mac_bc_next;
    logic [7:0]  opt_last;
    logic [15:0] dport;
    logic [15:0] port_off;
    logic        accept_now;
    logic        csum_bad;

    assign eth_idx     = cnt + 8'd1;
    assign mac_uc_next = mac_uc_ok && (in_data == mac_byte(eth_idx));
    assign mac_bc_next = mac_bc_ok && (in_data == 8'hFF);
    assign opt_last    = {2'b00, ihl - 4'd5, 2'b00} - 8'd1;
    assign dport       = {hi_byte, in_data};
    assign port_off    = dport - PORT_BASE;
    assign accept_now  = (state == PAD) || (state == PAYLOAD && remaining == 16'd1);

`ifdef IP_CSUM_CHECK_EN
    logic        csum_clr;
    logic        csum_en;
    logic [15:0] csum_sum;

    assign csum_clr = !(state == IP_HEADER || state == IP_OPTIONS);
    assign csum_en  = in_valid && !csum_clr;
    assign csum_bad = (csum_sum != 16'hFFFF);

    ip_csum_acc u_ip_csum (
        .clk       (clk),
        .rst       (rst),
        .clr       (csum_clr),
        .byte_valid(csum_en),
        .byte_data (in_data),
        .sum       (csum_sum)
    );
`else
    assign csum_bad = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            mac_uc_ok   <= 1'b0;
            mac_bc_ok   <= 1'b0;
            ihl         <= '0;
            hi_byte     <= '0;
            udp_len     <= '0;
            remaining   <= '0;
            chan_ok     <= 1'b0;
            chan_r      <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_last    <= 1'b0;
            out_chan    <= '0;
            stat_valid  <= 1'b0;
            stat_good   <= 1'b0;
            rx_good_cnt <= '0;
            rx_drop_cnt <= '0;
        end else begin
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            stat_valid <= 1'b0;
            stat_good  <= 1'b0;

            if (in_valid) begin
                // NOTE: non-blocking assignments take the last write in the block, so a
                // state change below can override this increment with a clear.
                cnt <= cnt + 8'd1;

                case (state)
                    IDLE: begin
                        mac_uc_ok <= (in_data == mac_byte(8'd0));
                        mac_bc_ok <= (in_data == 8'hFF);
                        state     <= ETH_HEADER;
                        cnt       <= '0;
                    end

                    ETH_HEADER: begin
                        if (eth_idx < 8'd6) begin
                            mac_uc_ok <= mac_uc_next;
                            mac_bc_ok <= mac_bc_next;
                            if (eth_idx == 8'd5 && !(mac_uc_next || mac_bc_next)) begin
                                state <= DROP;
                                cnt   <= '0;
                            end
                        end else if (eth_idx == ETH_HDR_LEN - 8'd2) begin
                            if (in_data != ETHERTYPE_IPV4[15:8]) begin
                                state <= DROP;
                                cnt   <= '0;
                            end
                        end else if (eth_idx == ETH_HDR_LEN - 8'd1) begin
                            state <= (in_data == ETHERTYPE_IPV4[7:0]) ? IP_HEADER : DROP;
                            cnt   <= '0;
                        end
                    end

                    IP_HEADER: begin
                        case (cnt)
                            8'd0: begin
                                ihl <= in_data[3:0];
                                if (in_data[7:4] != 4'd4 || in_data[3:0] < 4'd5) begin
                                    state <= DROP;
                                    cnt   <= '0;
                                end
                            end
                            8'd6: begin
                                if (in_data[5] || in_data[4:0] != 5'd0) begin
                                    state <= DROP;
                                    cnt   <= '0;
                                end
                            end
                            8'd7, 8'd9: begin
                                if (in_data != ((cnt == 8'd7) ? 8'd0 : IP_PROTO_UDP)) begin
                                    state <= DROP;
                                    cnt   <= '0;
                                end
                            end
                            8'd16, 8'd17, 8'd18: begin
                                if (in_data != ip_byte(cnt[1:0])) begin
                                    state <= DROP;
                                    cnt   <= '0;
                                end
                            end
                            IP_HDR_MIN_LEN - 8'd1: begin
                                cnt <= '0;
                                if (in_data != ip_byte(cnt[1:0])) begin
                                    state <= DROP;
                                end else if (ihl > 4'd5) begin
                                    state <= IP_OPTIONS;
                                end else begin
                                    state <= csum_bad ? DROP : UDP_HEADER;
                                end
                            end
                            default: ;
                        endcase
                    end

                    IP_OPTIONS: begin
                        if (cnt == opt_last) begin
                            state <= csum_bad ? DROP : UDP_HEADER;
                            cnt   <= '0;
                        end
                    end

                    UDP_HEADER: begin
                        case (cnt)
                            8'd2, 8'd4: hi_byte <= in_data;
                            8'd3: begin
                                chan_ok <= (dport >= PORT_BASE) && (port_off < NUM_CHAN_16);
                                chan_r  <= port_off[CHAN_W-1:0];
                            end
                            8'd5: udp_len <= dport;
                            UDP_HDR_LEN - 8'd1: begin
                                cnt <= '0;
                                if (!chan_ok || udp_len < {8'd0, UDP_HDR_LEN}) begin
                                    state <= DROP;
                                end else if (udp_len == {8'd0, UDP_HDR_LEN}) begin
                                    state <= PAD;
                                end else begin
                                    remaining <= udp_len - {8'd0, UDP_HDR_LEN};
                                    out_chan  <= chan_r;
                                    state     <= PAYLOAD;
                                end
                            end
                            default: ;
                        endcase
                    end

                    PAYLOAD: begin
                        out_valid <= 1'b1;
                        out_data  <= in_data;
                        out_last  <= (remaining == 16'd1) || in_last;
                        remaining <= remaining - 16'd1;
                        if (remaining == 16'd1) begin
                            state <= PAD;
                            cnt   <= '0;
                        end
                    end

                    default: ;
                endcase

                // End of frame wins over any header decision made on the same byte.
                if (in_last) begin
                    state      <= IDLE;
                    cnt        <= '0;
                    stat_valid <= 1'b1;
                    stat_good  <= accept_now && !in_fcs_bad;
                    if (accept_now && !in_fcs_bad) begin
                        rx_good_cnt <= rx_good_cnt + CNT_W'(1);
                    end else begin
                        rx_drop_cnt <= rx_drop_cnt + CNT_W'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_udp_rx_parser.sv
// Directed self-checking bench for udp_rx_parser: hand-built frames with expected payload,
// channel, status and counter values. Checksum expectations follow IP_CSUM_CHECK_EN.
module tb_udp_rx_parser;

    localparam logic [47:0] LOCAL_MAC = 48'h02_00_00_00_00_01;
    localparam logic [47:0] BCAST_MAC = 48'hFF_FF_FF_FF_FF_FF;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_last;
    logic        in_fcs_bad;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_last;
    logic [2:0]  out_chan;
    logic        stat_valid;
    logic        stat_good;
    logic [31:0] rx_good_cnt;
    logic [31:0] rx_drop_cnt;

    always #5 clk = ~clk;

    udp_rx_parser dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_last    (in_last),
        .in_fcs_bad (in_fcs_bad),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_last   (out_last),
        .out_chan   (out_chan),
        .stat_valid (stat_valid),
        .stat_good  (stat_good),
        .rx_good_cnt(rx_good_cnt),
        .rx_drop_cnt(rx_drop_cnt)
    );

    int         n_vec = 0;
    int         n_err = 0;
    int         exp_good = 0;
    int         exp_drop = 0;
    int         n_stat = 0;
    logic       last_stat_good = 1'b0;
    logic [7:0] f[$];
    logic [7:0] obs_data[$];
    logic       obs_last[$];
    logic [2:0] obs_chan[$];
    logic [7:0] pay[4] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};

    always @(negedge clk) begin
        if (out_valid) begin
            obs_data.push_back(out_data);
            obs_last.push_back(out_last);
            obs_chan.push_back(out_chan);
        end
        if (stat_valid) begin
            n_stat++;
            last_stat_good = stat_good;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic build(input logic [47:0] dmac, input logic [15:0] etype,
                         input logic [3:0] ihl, input logic [15:0] dport,
                         input logic [15:0] udp_len, input int npay,
                         input logic [15:0] csum_err, input int pad_to);
        logic [7:0]  ip[$];
        logic [31:0] s;
        logic [15:0] csum;
        logic [15:0] tot;
        f.delete();
        for (int i = 0; i < 6; i++) f.push_back(dmac[47-8*i -: 8]);
        f.push_back(8'h02); f.push_back(8'h00); f.push_back(8'h00);
        f.push_back(8'h00); f.push_back(8'h00); f.push_back(8'h99);
        f.push_back(etype[15:8]); f.push_back(etype[7:0]);
        tot = {10'd0, ihl, 2'b00} + udp_len;
        ip = '{8'h40 | {4'h0, ihl}, 8'h00, tot[15:8], tot[7:0], 8'h00, 8'h00, 8'h40, 8'h00,
               8'h40, 8'd17, 8'h00, 8'h00, 8'hC0, 8'hA8, 8'h01, 8'h01,
               8'hC0, 8'hA8, 8'h01, 8'h64};
        for (int i = 0; i < (int'(ihl) - 5) * 4; i++) ip.push_back(8'h01);
        s = '0;
        for (int i = 0; i + 1 < ip.size(); i += 2) s = s + {16'd0, ip[i], ip[i+1]};
        s = {16'd0, s[15:0]} + {16'd0, s[31:16]};
        s = {16'd0, s[15:0]} + {16'd0, s[31:16]};
        csum = ~s[15:0] + csum_err;
        ip[10] = csum[15:8];
        ip[11] = csum[7:0];
        foreach (ip[i]) f.push_back(ip[i]);
        f.push_back(8'h04); f.push_back(8'hD2);
        f.push_back(dport[15:8]); f.push_back(dport[7:0]);
        f.push_back(udp_len[15:8]); f.push_back(udp_len[7:0]);
        f.push_back(8'h00); f.push_back(8'h00);
        for (int i = 0; i < npay; i++) f.push_back(pay[i]);
        while (f.size() < pad_to) f.push_back(8'h00);
    endtask

    task automatic send(input int n, input logic fcs_bad);
        for (int i = 0; i < n; i++) begin
            in_valid   = 1'b1;
            in_data    = f[i];
            in_last    = (i == n - 1);
            in_fcs_bad = fcs_bad && (i == n - 1);
            @(posedge clk); #1;
        end
        in_valid   = 1'b0;
        in_data    = 8'h00;
        in_last    = 1'b0;
        in_fcs_bad = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic clear_obs();
        obs_data.delete();
        obs_last.delete();
        obs_chan.delete();
        n_stat = 0;
    endtask

    task automatic check_frame(input string tag, input int nbeats, input logic [2:0] chan,
                               input logic good);
        check({tag, ".beats"}, 64'(obs_data.size()), 64'(nbeats));
        for (int i = 0; i < obs_data.size() && i < nbeats; i++) begin
            check($sformatf("%s.data%0d", tag, i), 64'(obs_data[i]), 64'(pay[i]));
            check($sformatf("%s.last%0d", tag, i), 64'(obs_last[i]), 64'(i == nbeats - 1));
            check($sformatf("%s.chan%0d", tag, i), 64'(obs_chan[i]), 64'(chan));
        end
        check({tag, ".stat_n"}, 64'(n_stat), 64'd1);
        check({tag, ".stat_good"}, 64'(last_stat_good), 64'(good));
        if (good) exp_good++;
        else exp_drop++;
        check({tag, ".good_cnt"}, 64'(rx_good_cnt), 64'(exp_good));
        check({tag, ".drop_cnt"}, 64'(rx_drop_cnt), 64'(exp_drop));
        clear_obs();
    endtask

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_data    = 8'h00;
        in_last    = 1'b0;
        in_fcs_bad = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst.out_valid", 64'(out_valid), 64'd0);
        check("rst.out_last", 64'(out_last), 64'd0);
        check("rst.out_data", 64'(out_data), 64'd0);
        check("rst.out_chan", 64'(out_chan), 64'd0);
        check("rst.stat_valid", 64'(stat_valid), 64'd0);
        check("rst.good_cnt", 64'(rx_good_cnt), 64'd0);
        check("rst.drop_cnt", 64'(rx_drop_cnt), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        clear_obs();

        build(LOCAL_MAC, 16'h0800, 4'd5, 16'd5002, 16'd12, 4, 16'd0, 60);
        send(f.size(), 1'b0);
        check_frame("basic", 4, 3'd2, 1'b1);

        build(LOCAL_MAC, 16'h0800, 4'd5, 16'd5004, 16'd12, 4, 16'd0, 60);
        send(f.size(), 1'b0);
        check_frame("port_hi", 0, 3'd0, 1'b0);

        build(LOCAL_MAC, 16'h0800, 4'd6, 16'd5002, 16'd12, 4, 16'd0, 60);
        send(f.size(), 1'b0);
        check_frame("ip_opts", 4, 3'd2, 1'b1);

        build(LOCAL_MAC, 16'h0800, 4'd5, 16'd5002, 16'd12, 4, 16'd0, 60);
        send(44, 1'b0);
        check_frame("trunc", 2, 3'd2, 1'b0);

        send(f.size(), 1'b1);
        check_frame("fcs_bad", 4, 3'd2, 1'b0);

        send(10, 1'b0);
        check_frame("eth_trunc", 0, 3'd0, 1'b0);

        build(BCAST_MAC, 16'h0800, 4'd5, 16'd5002, 16'd12, 4, 16'd0, 60);
        send(f.size(), 1'b0);
        check_frame("bcast", 4, 3'd2, 1'b1);

        build(48'h02_00_00_00_00_02, 16'h0800, 4'd5, 16'd5002, 16'd12, 4, 16'd0, 60);
        send(f.size(), 1'b0);
        check_frame("mac_miss", 0, 3'd0, 1'b0);

        build(LOCAL_MAC, 16'h86DD, 4'd5, 16'd5002, 16'd12, 4, 16'd0, 60);
        send(f.size(), 1'b0);
        check_frame("etype", 0, 3'd0, 1'b0);

        build(LOCAL_MAC, 16'h0800, 4'd5, 16'd4999, 16'd12, 4, 16'd0, 60);
        send(f.size(), 1'b0);
        check_frame("port_lo", 0, 3'd0, 1'b0);

        build(LOCAL_MAC, 16'h0800, 4'd5, 16'd5003, 16'd12, 4, 16'd0, 60);
        send(f.size(), 1'b0);
        check_frame("chan3", 4, 3'd3, 1'b1);

        build(LOCAL_MAC, 16'h0800, 4'd5, 16'd5000, 16'd8, 0, 16'd0, 60);
        send(f.size(), 1'b0);
        check_frame("empty", 0, 3'd0, 1'b1);

        build(LOCAL_MAC, 16'h0800, 4'd5, 16'd5002, 16'd12, 4, 16'd0, 0);
        send(f.size(), 1'b0);
        check_frame("no_pad", 4, 3'd2, 1'b1);

        build(LOCAL_MAC, 16'h0800, 4'd4, 16'd5002, 16'd12, 4, 16'd0, 60);
        send(f.size(), 1'b0);
        check_frame("ihl4", 0, 3'd0, 1'b0);

        build(LOCAL_MAC, 16'h0800, 4'd5, 16'd5001, 16'd12, 4, 16'd1, 60);
        send(f.size(), 1'b0);
`ifdef IP_CSUM_CHECK_EN
        check_frame("csum", 0, 3'd0, 1'b0);
`else
        check_frame("csum", 4, 3'd1, 1'b1);
`endif

        // Reset in the middle of a payload: beats so far carry no out_last.
        build(LOCAL_MAC, 16'h0800, 4'd5, 16'd5002, 16'd12, 4, 16'd0, 60);
        for (int i = 0; i < 44; i++) begin
            in_valid = 1'b1;
            in_data  = f[i];
            @(posedge clk); #1;
        end
        rst      = 1'b1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("mid_rst.out_valid", 64'(out_valid), 64'd0);
        check("mid_rst.out_data", 64'(out_data), 64'd0);
        check("mid_rst.out_chan", 64'(out_chan), 64'd0);
        check("mid_rst.good_cnt", 64'(rx_good_cnt), 64'd0);
        check("mid_rst.drop_cnt", 64'(rx_drop_cnt), 64'd0);
        check("mid_rst.beats", 64'(obs_data.size()), 64'd2);
        foreach (obs_last[i]) check($sformatf("mid_rst.last%0d", i), 64'(obs_last[i]), 64'd0);
        check("mid_rst.stat_n", 64'(n_stat), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        clear_obs();
        exp_good = 0;
        exp_drop = 0;
        send(f.size(), 1'b0);
        check_frame("after_rst", 4, 3'd2, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
